// File: rtl/sseg_signed_scan_if.sv
// sseg_signed_scan_if: bundles the load/convert handshake and the display
// outputs of sseg_signed_scan. The driver side (master) presents a magnitude
// and sign with a one-cycle load strobe. The display driver (slave) reports
// busy, overflow, segments and anodes.
//
// Handshake: load is honoured on a rising clock edge only while busy=0. At
// that edge value_in/neg_in are captured. busy is high from that edge until
// the edge that commits the result, and loads seen while busy=1 are dropped.
// dbg_state mirrors the conversion FSM state for observation.
`timescale 1ns/1ps
interface sseg_signed_scan_if #(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
);
  logic [WIDTH-1:0] value_in;
  logic             neg_in;
  logic             load;
  logic             busy;
  logic             ovf;
  logic [6:0]       SSeg;
  logic [DIGITS:0]  an;
  logic [1:0]       dbg_state;

  modport master (
    output value_in, neg_in, load,
    input  busy, ovf, SSeg, an, dbg_state
  );

  modport slave (
    input  value_in, neg_in, load,
    output busy, ovf, SSeg, an, dbg_state
  );
endinterface

// File: rtl/sseg_signed_scan.sv
// sseg_signed_scan: signed-magnitude 7-segment driver. A sequential
// double-dabble engine converts the loaded magnitude to BCD. Results are
// committed to display registers in a single cycle, and the display is
// time-multiplexed over DIGITS magnitude digits plus one sign digit
// (common anode, active-low segments and anodes).
// Optional build macro: SSEG_LZ_BLANK_EN blanks leading zero digits.
`timescale 1ns/1ps
module sseg_signed_scan #(
  parameter int WIDTH    = 9,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  sseg_signed_scan_if.slave  bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              wovf_q, wovf_d;
  logic              wsign_q, wsign_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     disp_q, disp_d;
  logic              dovf_q, dovf_d;
  logic              dsign_q, dsign_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [IW-1:0]     idx_q, idx_d;

  logic [BW-1:0]     adj;
  logic [DIGITS-1:0] lz;
  logic              hz;
  logic [DIGITS:0]   one_hot;
  logic [6:0]        seg;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = SEG_BLANK;
    endcase
  endfunction

  // add-3 correction of every BCD nibble that is 5 or more before the shift
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // conversion FSM: capture, WIDTH shift steps, then one-cycle commit
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    wovf_d  = wovf_q;
    wsign_d = wsign_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    dovf_d  = dovf_q;
    dsign_d = dsign_q;
    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          sh_d    = bus.value_in;
          // a zero magnitude never displays as negative
          wsign_d = bus.neg_in & (|bus.value_in);
          bcd_d   = '0;
          wovf_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_d = {adj[BW-2:0], sh_q[WIDTH-1]};
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        // a bit leaving the top nibble means the value needs another digit
        if (adj[BW-1]) wovf_d = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        disp_d  = bcd_q;
        dovf_d  = wovf_q;
        dsign_d = wsign_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // scan prescaler and digit index, free-running regardless of conversions
  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PW'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IW'(DIGITS)) ? '0 : idx_q + 1'b1;
    end
  end

  // register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      wovf_q  <= 1'b0;
      wsign_q <= 1'b0;
      cnt_q   <= '0;
      disp_q  <= '0;
      dovf_q  <= 1'b0;
      dsign_q <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      wovf_q  <= wovf_d;
      wsign_q <= wsign_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      dovf_q  <= dovf_d;
      dsign_q <= dsign_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
    end
  end

  // leading-zero mask: digit k blanks when it and all higher digits are 0
  always_comb begin
    lz = '0;
    hz = 1'b1;
`ifdef SSEG_LZ_BLANK_EN
    for (int k = DIGITS - 1; k >= 1; k--) begin
      hz    = hz & (disp_q[4*k +: 4] == 4'd0);
      lz[k] = hz;
    end
`endif
  end

  // segment select for the currently lit position
  always_comb begin
    seg = SEG_BLANK;
    if (idx_q == IW'(DIGITS)) begin
      seg = dsign_q ? SEG_DASH : SEG_BLANK;
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        if (idx_q == IW'(k)) begin
          if (dovf_q)     seg = SEG_DASH;
          else if (lz[k]) seg = SEG_BLANK;
          else            seg = dec7(disp_q[4*k +: 4]);
        end
      end
    end
  end

  // active-low one-hot anode drive
  always_comb begin
    one_hot        = '0;
    one_hot[idx_q] = 1'b1;
  end

  assign bus.an        = ~one_hot;
  assign bus.SSeg      = seg;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.ovf       = dovf_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_sseg_signed_scan.sv
// tb_sseg_signed_scan: exercises a 3-digit and a 2-digit instance of
// sseg_signed_scan (WIDTH=9, SCAN_DIV=4). Expected segment codes per display
// position are queued when a load is driven and checked against one scan frame
// after the conversion completes.
`timescale 1ns/1ps
module tb_sseg_signed_scan;
  localparam int WIDTH    = 9;
  localparam int SCAN_DIV = 4;
`ifdef SSEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  logic [6:0] exp_q[$];
  logic [0:0] ovf_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  sseg_signed_scan_if #(.WIDTH(WIDTH), .DIGITS(3)) ifa ();
  sseg_signed_scan_if #(.WIDTH(WIDTH), .DIGITS(2)) ifb ();

  sseg_signed_scan #(.WIDTH(WIDTH), .DIGITS(3), .SCAN_DIV(SCAN_DIV)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  sseg_signed_scan #(.WIDTH(WIDTH), .DIGITS(2), .SCAN_DIV(SCAN_DIV)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b1000000;
      1: seg_of = 7'b1111001;
      2: seg_of = 7'b0100100;
      3: seg_of = 7'b0110000;
      4: seg_of = 7'b0011001;
      5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;
      7: seg_of = 7'b1111000;
      8: seg_of = 7'b0000000;
      default: seg_of = 7'b0010000;
    endcase
  endfunction

  function automatic int ndig(input int which);
    return (which == 0) ? 3 : 2;
  endfunction

  function automatic logic [3:0] an_exp(input int p, input int nd);
    logic [3:0] m;
    m = 4'((1 << (nd + 1)) - 1);
    return (~(4'b0001 << p)) & m;
  endfunction

  function automatic logic [3:0] get_an(input int which);
    return (which == 0) ? ifa.an : {1'b0, ifb.an};
  endfunction

  function automatic logic [6:0] get_seg(input int which);
    return (which == 0) ? ifa.SSeg : ifb.SSeg;
  endfunction

  function automatic logic get_busy(input int which);
    return (which == 0) ? ifa.busy : ifb.busy;
  endfunction

  function automatic logic get_ovf(input int which);
    return (which == 0) ? ifa.ovf : ifb.ovf;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver
  task automatic set_in(input int which, input int v, input bit neg, input bit ld);
    if (which == 0) begin
      ifa.value_in = WIDTH'(v);
      ifa.neg_in   = neg;
      ifa.load     = ld;
    end else begin
      ifb.value_in = WIDTH'(v);
      ifb.neg_in   = neg;
      ifb.load     = ld;
    end
  endtask

  // reference model: expected segment code per position, units first
  task automatic push_expect(input int v, input bit neg, input int nd);
    int lim;
    int p;
    bit ov;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    ov = (v >= lim);
    ovf_q.push_back(ov);
    p = 1;
    for (int k = 0; k < nd; k++) begin
      if (ov)                     exp_q.push_back(7'b0111111);
      else if (LZ && k > 0 && v < p) exp_q.push_back(7'b1111111);
      else                        exp_q.push_back(seg_of((v / p) % 10));
      p = p * 10;
    end
    exp_q.push_back((neg && v != 0) ? 7'b0111111 : 7'b1111111);
  endtask

  task automatic wait_idle(input int which, output int cnt);
    cnt = 0;
    while (get_busy(which) && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  // move to the first cycle where the units digit becomes lit
  task automatic align(input int which, output bit ok);
    logic [3:0] prev;
    logic [3:0] a0;
    a0   = an_exp(0, ndig(which));
    ok   = 1'b0;
    prev = get_an(which);
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (get_an(which) == a0 && prev != a0) ok = 1'b1;
      prev = get_an(which);
    end
  endtask

  task automatic check_frame(input int which, input string tag);
    bit ok;
    int nd;
    logic [6:0] e;
    nd = ndig(which);
    align(which, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s align: an never reached %b", tag, an_exp(0, nd));
      for (int p = 0; p <= nd; p++) void'(exp_q.pop_front());
      return;
    end
    for (int p = 0; p <= nd; p++) begin
      n_vec++;
      if (get_an(which) !== an_exp(p, nd)) begin
        n_err++;
        $display("FAIL %s an[pos %0d]: got %b want %b", tag, p, get_an(which), an_exp(p, nd));
      end
      e = exp_q.pop_front();
      n_vec++;
      if (get_seg(which) !== e) begin
        n_err++;
        $display("FAIL %s SSeg[pos %0d]: got %b want %b", tag, p, get_seg(which), e);
      end
      repeat (SCAN_DIV) tick();
    end
  endtask

  task automatic check_done(input int which, input int cnt, input string tag);
    logic [0:0] eo;
    n_vec++;
    if (cnt !== WIDTH + 1) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d want %0d", tag, cnt, WIDTH + 1);
    end
    eo = ovf_q.pop_front();
    n_vec++;
    if (get_ovf(which) !== eo[0]) begin
      n_err++;
      $display("FAIL %s ovf: got %b want %b", tag, get_ovf(which), eo[0]);
    end
  endtask

  task automatic run_conv(input int which, input int v, input bit neg, input string tag);
    int cnt;
    push_expect(v, neg, ndig(which));
    set_in(which, v, neg, 1'b1);
    tick();
    set_in(which, v, neg, 1'b0);
    wait_idle(which, cnt);
    check_done(which, cnt, tag);
    check_frame(which, tag);
  endtask

  task automatic check_reset_outputs(input int which, input string tag);
    n_vec++;
    if (get_busy(which) !== 1'b0) begin
      n_err++; $display("FAIL %s busy: got %b want 0", tag, get_busy(which));
    end
    n_vec++;
    if (get_ovf(which) !== 1'b0) begin
      n_err++; $display("FAIL %s ovf: got %b want 0", tag, get_ovf(which));
    end
    n_vec++;
    if (get_an(which) !== an_exp(0, ndig(which))) begin
      n_err++; $display("FAIL %s an: got %b want %b", tag, get_an(which), an_exp(0, ndig(which)));
    end
    n_vec++;
    if (get_seg(which) !== 7'b1000000) begin
      n_err++; $display("FAIL %s SSeg: got %b want 1000000", tag, get_seg(which));
    end
  endtask

  task automatic test_reset();
    set_in(0, 0, 1'b0, 1'b0);
    set_in(1, 0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs(0, "reset_a");
    check_reset_outputs(1, "reset_b");
    rst = 1'b0;
    push_expect(0, 1'b0, 3);
    void'(ovf_q.pop_front());
    check_frame(0, "reset_frame");
  endtask

  task automatic test_convert();
    run_conv(0, 165, 1'b1, "conv_165n");
    run_conv(0, 7, 1'b0, "conv_7");
    run_conv(0, 0, 1'b1, "conv_minus0");
    run_conv(0, 511, 1'b1, "conv_511n");
    for (int i = 0; i < 5; i++) begin
      run_conv(0, $urandom_range(0, 511), 1'($urandom_range(0, 1)), "conv_rand");
    end
  endtask

  task automatic test_overflow();
    run_conv(1, 100, 1'b0, "ovf_100");
    run_conv(1, 99, 1'b0, "ovf_99");
    run_conv(1, 300, 1'b1, "ovf_300n");
    for (int i = 0; i < 4; i++) begin
      run_conv(1, $urandom_range(0, 200), 1'($urandom_range(0, 1)), "ovf_rand");
    end
  endtask

  task automatic test_load_ignored();
    int cnt;
    push_expect(165, 1'b0, 3);
    set_in(0, 165, 1'b0, 1'b1);
    tick();                       // E0
    set_in(0, 165, 1'b0, 1'b0);
    tick();                       // E1
    tick();                       // E2
    set_in(0, 300, 1'b1, 1'b1);
    tick();                       // E3
    set_in(0, 300, 1'b1, 1'b0);
    wait_idle(0, cnt);
    check_done(0, cnt + 3, "ignore_load");
    check_frame(0, "ignore_load");
  endtask

  task automatic test_reset_mid();
    set_in(0, 300, 1'b1, 1'b1);
    tick();                       // E0
    set_in(0, 300, 1'b1, 1'b0);
    repeat (4) tick();            // E1..E4
    rst = 1'b1;
    tick();                       // E5
    check_reset_outputs(0, "reset_mid");
    rst = 1'b0;
    push_expect(0, 1'b0, 3);
    void'(ovf_q.pop_front());
    check_frame(0, "reset_mid_frame");
  endtask

  task automatic test_back_to_back_scan();
    bit ok;
    align(0, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL idle_scan align: an never reached 1110");
      return;
    end
    // a conversion commits in the middle of this window
    set_in(0, 42, 1'b1, 1'b1);
    for (int c = 0; c < 32; c++) begin
      n_vec++;
      if (get_an(0) !== an_exp((c / SCAN_DIV) % 4, 3)) begin
        n_err++;
        $display("FAIL idle_scan an[cycle %0d]: got %b want %b", c, get_an(0), an_exp((c / SCAN_DIV) % 4, 3));
      end
      tick();
      if (c == 0) set_in(0, 42, 1'b1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_overflow();
    test_load_ignored();
    test_reset_mid();
    test_back_to_back_scan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sseg_signed_scan.md
# sseg_signed_scan

Parametrised signed-magnitude 7-segment display driver: accepts a binary magnitude plus sign flag on a load strobe, converts it to BCD with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes DIGITS magnitude digits plus one sign digit onto a common-anode display. It replaces the fixed 3-digit combinational converter/scan chain at the top of the display path and adds overflow detection, minus-zero suppression and optional leading-zero blanking.

## Interface
- WIDTH, 9, magnitude width in bits (≥ 2)
- DIGITS, 3, magnitude digit count (≥ 1); display has DIGITS+1 positions
- SCAN_DIV, 50000, clock cycles each digit stays lit (≥ 2)

- clk  in  1  system clock; the only clock
- rst  in  1  synchronous reset, active-high
- value_in  in  WIDTH  unsigned magnitude
- neg_in  in  1  1 = value is negative
- load  in  1  capture strobe, honoured only while busy=0
- busy  out  1  conversion in progress
- ovf  out  1  displayed value exceeded 10^DIGITS−1
- SSeg  out  7  segments {g,f,e,d,c,b,a}, active-low
- an  out  DIGITS+1  anode enables, active-low one-hot; bit 0 = units, bit DIGITS = sign

## Operation
- FSM: IDLE → SHIFT → COMMIT → IDLE.
- IDLE: load=1 captures value_in into shift reg, neg_in into sign latch, clears BCD work reg (4·DIGITS bits) and sticky overflow, bit counter=0 → SHIFT.
- SHIFT: per cycle, each BCD nibble ≥5 gets +3, then {BCD,shift} shifts left one bit MSB-first; a 1 leaving the top nibble sets sticky overflow. After WIDTH shifts → COMMIT.
- COMMIT: copy BCD work reg, overflow, and sign into display regs in one cycle; sign stored as neg AND (magnitude≠0), so −0 shows positive. → IDLE.
- load during SHIFT/COMMIT ignored; the running conversion is unaffected.
- Display regs change only in COMMIT; scan never shows partial results.
- Scan: prescaler 0..SCAN_DIV−1; at terminal count, digit index increments 0→1→…→DIGITS→0.
- an = ~(1 << index). SSeg, a function of registered state only:
  - index 0..DIGITS−1: standard decimal code of that nibble; when ovf, 7'b0111111 (dash) on every magnitude digit.
  - index DIGITS: 7'b0111111 if sign negative, else 7'b1111111 (blank).
- Codes: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000.

## Timing
- Load sampled at edge E0 → busy=1 from E0 through E_{WIDTH+1}; display regs and ovf update at E_{WIDTH+1}, where busy returns to 0. Latency = WIDTH+2 edges. A new load is accepted at E_{WIDTH+2} at the earliest.
- Each digit is lit for exactly SCAN_DIV cycles; full frame is (DIGITS+1)·SCAN_DIV cycles.
- Reset (any state, including mid-conversion): state IDLE, busy=0, ovf=0, display digits 0, sign positive, prescaler 0, index 0. Outputs the cycle after reset: an=~1, SSeg=1000000.
- Conversion and scan are independent; a COMMIT does not reset prescaler or index.

## Configuration
- SSEG_LZ_BLANK_EN defined: magnitude digit k (k≥1) is blank (7'b1111111) when it and every higher magnitude digit are 0. Units are never blanked. Overflow dashes override blanking.
- Undefined: all magnitude digits are always displayed, including leading zeros.

## Test plan
(WIDTH=9, DIGITS=3, SCAN_DIV=4 unless stated)
- value_in=165, neg_in=1, load → busy high 10 cycles, ovf=0. Scan: an 1110/1101/1011/0111 → SSeg 0010010/0000010/1111001/0111111.
- value_in=7, neg_in=0 → with SSEG_LZ_BLANK_EN, hundreds and tens 1111111, units 1111000, sign blank. Without it, hundreds and tens show 1000000.
- DIGITS=2, value_in=100 → ovf=1, both magnitude digits 0111111. Then load 99 → ovf=0, digits 0010000 0010000.
- value_in=0, neg_in=1 → sign position 1111111, units 1000000.
- load 165, then load 300 at E3 → 300 ignored, display shows 165. Load 300, assert rst at E5 → busy=0 next cycle, display shows 0, an=1110.
- Idle scan check: an sequence 1110→1101→1011→0111→1110, changing every 4 cycles, with no change when a COMMIT occurs.
